operation_frame_ctrl: RTL
=========================

// Module: operation_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the operation window pipeline (median-of-median -> sobel).
//  - On start: pulses refresh, then streams one frame of 8b pixels from the source.
//  - Attaches a 2b tag to each pixel, emits DATA_END_TAG after the last pixel.
//  - Waits for that END tag at the pipeline output, then reports done and counts frames.
// PARAMETERS
//  IMG_WIDTH       640   pixels per line (>=2)
//  IMG_HEIGHT      480   lines per frame (>=1)
//  TAG_WIDTH       2     tag bits
//  INVALID_TAG     2'd0  tag for no data
//  DATA_TAG0       2'd1  tag for valid pixel, not first in line
//  DATA_TAG1       2'd2  tag for valid pixel, first in line (col 0)
//  DATA_END_TAG    2'd3  tag for end of frame
//  TIMEOUT_CYCLES  1024  flush watchdog limit (used only with FRAME_TIMEOUT_EN)
// PORTS
//  clk          in   1          clock, all logic on posedge
//  rst          in   1          asynchronous reset, active-high
//  start        in   1          begin a frame; sampled only in IDLE
//  abort        in   1          synchronous frame abort
//  src_valid    in   1          source pixel valid
//  src_ready    out  1          controller accepts pixel (valid & ready = transfer)
//  src_pixel    in   8          source pixel value
//  pix_out      out  8+TAG_WIDTH  {tag, pixel} to the operation window line buffers
//  refresh      out  1          frame-start pulse to the operation pipeline
//  op_tag       in   TAG_WIDTH  tag field of the operation block output (out[9:8])
//  busy         out  1          state != IDLE
//  done         out  1          one-cycle pulse: frame fully drained
//  err          out  1          sticky watchdog error
//  frame_cnt    out  16         completed frames, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset values: state=IDLE; src_ready=0; pix_out={INVALID_TAG,8'd0}; refresh=0; busy=0;
//    done=0; err=0; frame_cnt=0; col=row=0.
//  FSM states: IDLE, REFRESH, STREAM, FLUSH, DONE.
//  - IDLE -> REFRESH when start=1.
//  - REFRESH (exactly 1 cycle, refresh=1, counters cleared) -> STREAM.
//  - STREAM: src_ready=1 combinationally. On transfer:
//    - pix_out <= {col==0 ? DATA_TAG1 : DATA_TAG0, src_pixel}; 1-cycle latency.
//    - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
//    - transfer at col=W-1, row=H-1 -> FLUSH.
//    - Cycles without a transfer: pix_out <= {INVALID_TAG, 8'd0}.
//  - FLUSH: src_ready=0.
//    - First FLUSH cycle: pix_out <= {DATA_END_TAG, 8'd0}; afterwards INVALID.
//    - Next state is DONE once op_tag==DATA_END_TAG is seen, but never in the first FLUSH cycle.
//    - An op_tag END seen in any other state is ignored.
//  - DONE (1 cycle): done=1; frame_cnt+1 (16-bit, wraps) -> IDLE.
//  - abort=1 in any non-IDLE state -> REFRESH (flushes the pipeline); counters cleared;
//    no done, frame_cnt unchanged; pix_out <= INVALID next cycle.
//  - abort=1 in IDLE has no effect. abort and start together in IDLE: start wins.
//  - start outside IDLE is ignored. err clears on an accepted start.
//  - rst asserted mid-frame: immediate return to reset values; an in-flight frame is lost.
// CONFIGURATION
//  FRAME_TIMEOUT_EN defined:
//    - Watchdog counts FLUSH cycles.
//    - At count==TIMEOUT_CYCLES with no END seen: err<=1, -> IDLE, no done, frame_cnt unchanged.
//    - END arriving in the same cycle as the timeout wins: done, no err.
//  FRAME_TIMEOUT_EN undefined:
//    - No watchdog counter; FLUSH waits indefinitely; err is tied to 0.
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=3, TIMEOUT_CYCLES=16)
//  1. rst pulse mid-STREAM -> next edge all outputs at reset values, busy=0, frame_cnt=0.
//  2. start, src_valid held 1, pixels 1..12; op_tag=END 5 cycles after FLUSH entry:
//     - refresh 1 cycle; tags 2,1,1,1 repeated per line; then pix_out=10'h300.
//     - done pulses once; frame_cnt=1.
//  3. src_valid toggled 1/0 during STREAM -> INVALID tags in gap cycles; still 12 pixels,
//     col/row sequence correct.
//  4. abort at pixel 7 -> refresh pulses again; restarted frame needs 12 pixels;
//     frame_cnt unchanged until its done.
//  5. start asserted during STREAM and FLUSH -> no effect; exactly one done per frame.
//  6. FRAME_TIMEOUT_EN, op_tag never END -> 16 FLUSH cycles then err=1, IDLE, no done;
//     next start clears err.

Source files
------------

// File: rtl/operation_frame_ctrl.sv
// Frame sequencer for the median/sobel operation window: refresh pulse, tagged pixel stream, END-tag drain.
// Optional flush watchdog enabled by defining FRAME_TIMEOUT_EN.
module operation_frame_ctrl #(
  parameter int                   IMG_WIDTH      = 640,
  parameter int                   IMG_HEIGHT     = 480,
  parameter int                   TAG_WIDTH      = 2,
  parameter logic [TAG_WIDTH-1:0] INVALID_TAG    = TAG_WIDTH'(0),
  parameter logic [TAG_WIDTH-1:0] DATA_TAG0      = TAG_WIDTH'(1),
  parameter logic [TAG_WIDTH-1:0] DATA_TAG1      = TAG_WIDTH'(2),
  parameter logic [TAG_WIDTH-1:0] DATA_END_TAG   = TAG_WIDTH'(3),
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [7:0]             src_pixel,
  output logic [TAG_WIDTH+7:0]   pix_out,
  output logic                   refresh,
  input  logic [TAG_WIDTH-1:0]   op_tag,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            frame_cnt
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [2:0] {IDLE, REFRESH, STREAM, FLUSH, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            first_flush;
  logic            end_seen;

  // An abort withdraws ready so the source never believes a dropped pixel was taken.
  assign src_ready = (state == STREAM) && !abort;
  assign busy      = (state != IDLE);
  assign refresh   = (state == REFRESH);
  assign done      = (state == DONE);
  assign end_seen  = (op_tag == DATA_END_TAG) && !first_flush;

`ifdef FRAME_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pix_out     <= {INVALID_TAG, 8'd0};
      col         <= '0;
      row         <= '0;
      first_flush <= 1'b0;
      frame_cnt   <= 16'd0;
`ifdef FRAME_TIMEOUT_EN
      wd_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      pix_out <= {INVALID_TAG, 8'd0};
      if (abort && state != IDLE) begin
        state <= REFRESH;
        col   <= '0;
        row   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= REFRESH;
`ifdef FRAME_TIMEOUT_EN
              err_q <= 1'b0;
`endif
            end
          end
          REFRESH: begin
            col   <= '0;
            row   <= '0;
            state <= STREAM;
          end
          STREAM: begin
            if (src_valid) begin
              pix_out <= {(col == '0) ? DATA_TAG1 : DATA_TAG0, src_pixel};
              if (col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                if (row == RW'(IMG_HEIGHT - 1)) begin
                  row         <= '0;
                  state       <= FLUSH;
                  first_flush <= 1'b1;
`ifdef FRAME_TIMEOUT_EN
                  wd_cnt      <= '0;
`endif
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          FLUSH: begin
            first_flush <= 1'b0;
            if (first_flush)
              pix_out <= {DATA_END_TAG, 8'd0};
`ifdef FRAME_TIMEOUT_EN
            wd_cnt <= wd_cnt + 1'b1;
            // END in the timeout cycle still completes the frame.
            if (end_seen)
              state <= DONE;
            else if (wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
              err_q <= 1'b1;
              state <= IDLE;
            end
`else
            if (end_seen)
              state <= DONE;
`endif
          end
          DONE: begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
